// File: rtl/ddr3_lane_dm_tx_ctrl.sv
// ddr3_lane_dm_tx_ctrl: DM lane write-mask/OE serializer feed and delay-line sequencer; DM_BURST_COUNT_EN adds BURST_CNT
module ddr3_lane_dm_tx_ctrl #(
  parameter int WRITE_LATENCY = 4,
  parameter int MOVE_GAP = 4
) (
  input  logic       FAB_CLK,
  input  logic       TX_SYNC_RST,
  input  logic       WR_VALID,
  output logic       WR_READY,
  input  logic [7:0] WR_MASK,
  input  logic       DLY_CMD_VALID,
  input  logic       DLY_CMD_LOAD,
  input  logic       DLY_CMD_DIR,
  input  logic [7:0] DLY_CMD_STEPS,
  output logic       DLY_BUSY,
  output logic       DLY_DONE,
  output logic       DLY_ERR,
  output logic [7:0] TX_DATA_0,
  output logic [3:0] OE_DATA_0,
  output logic       DELAY_LINE_MOVE_0,
  output logic       DELAY_LINE_DIRECTION_0,
  output logic       DELAY_LINE_LOAD_0,
`ifdef DM_BURST_COUNT_EN
  output logic [15:0] BURST_CNT,
`endif
  input  logic       DELAY_LINE_OUT_OF_RANGE_0
);
  typedef enum logic [2:0] {IDLE, LOAD, MOVE, GAP, DONE} state_t;
  state_t state, state_nxt;
  logic [7:0] rem;
  logic [3:0] gcnt;
  logic dir, tx_v, acc;
  logic [8:0] pipe [WRITE_LATENCY-1];
  logic [8:0] chain [WRITE_LATENCY];
  assign DLY_BUSY = state != IDLE;
  assign WR_READY = !DLY_BUSY && !TX_SYNC_RST;
  assign acc = WR_VALID && WR_READY;
  assign DLY_DONE = state == DONE;
  assign DELAY_LINE_MOVE_0 = state == MOVE;
  assign DELAY_LINE_LOAD_0 = state == LOAD;
  assign DELAY_LINE_DIRECTION_0 = dir;
  always_comb begin
    chain[0] = {acc, acc ? WR_MASK : 8'h00};
    for (int i = 1; i < WRITE_LATENCY; i++) chain[i] = pipe[i-1];
  end
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      for (int i = 0; i < WRITE_LATENCY-1; i++) pipe[i] <= '0;
      tx_v <= 1'b0;
      TX_DATA_0 <= 8'h00;
      OE_DATA_0 <= 4'h0;
    end else begin
      for (int i = 0; i < WRITE_LATENCY-1; i++) pipe[i] <= chain[i];
      tx_v <= chain[WRITE_LATENCY-1][8];
      TX_DATA_0 <= chain[WRITE_LATENCY-1][7:0];
      OE_DATA_0 <= {4{chain[WRITE_LATENCY-1][8]}} | {chain[WRITE_LATENCY-2][8], 3'b000} | {3'b000, tx_v};
    end
  end
`ifdef DM_BURST_COUNT_EN
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) BURST_CNT <= 16'h0000;
    else if (chain[WRITE_LATENCY-1][8] && BURST_CNT != 16'hFFFF) BURST_CNT <= BURST_CNT + 16'h0001;
  end
`endif
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (DLY_CMD_VALID) state_nxt = DLY_CMD_LOAD ? LOAD : (DLY_CMD_STEPS == 8'h00 ? DONE : MOVE);
      LOAD: state_nxt = DONE;
      MOVE: state_nxt = GAP;
      GAP:  state_nxt = DELAY_LINE_OUT_OF_RANGE_0 ? DONE : (gcnt != 4'h0 ? GAP : (rem != 8'h00 ? MOVE : DONE));
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state <= IDLE;
      rem <= 8'h00;
      gcnt <= 4'h0;
      dir <= 1'b0;
      DLY_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && DLY_CMD_VALID) begin
        rem <= DLY_CMD_STEPS;
        dir <= DLY_CMD_DIR;
        DLY_ERR <= 1'b0;
      end
      if (state == MOVE) begin
        rem <= rem - 8'h01;
        gcnt <= 4'(MOVE_GAP - 2);
      end
      if (state == GAP) gcnt <= gcnt - 4'h1;
      if (state == GAP && DELAY_LINE_OUT_OF_RANGE_0) DLY_ERR <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ddr3_lane_dm_tx_ctrl.sv
// tb_ddr3_lane_dm_tx_ctrl: scoreboard bench for the DM lane write path and delay sequencer
module tb_ddr3_lane_dm_tx_ctrl;
  localparam int WL = 4;
  localparam int MG = 4;
  logic FAB_CLK = 1'b0;
  logic TX_SYNC_RST = 1'b1;
  logic WR_VALID = 1'b0;
  logic [7:0] WR_MASK = 8'h00;
  logic DLY_CMD_VALID = 1'b0, DLY_CMD_LOAD = 1'b0, DLY_CMD_DIR = 1'b0;
  logic [7:0] DLY_CMD_STEPS = 8'h00;
  logic DELAY_LINE_OUT_OF_RANGE_0 = 1'b0;
  logic WR_READY, DLY_BUSY, DLY_DONE, DLY_ERR;
  logic [7:0] TX_DATA_0;
  logic [3:0] OE_DATA_0;
  logic DELAY_LINE_MOVE_0, DELAY_LINE_DIRECTION_0, DELAY_LINE_LOAD_0;
`ifdef DM_BURST_COUNT_EN
  logic [15:0] BURST_CNT;
`endif
  int errors = 0;
  int checks = 0;
  typedef struct packed {logic [7:0] tx; logic [3:0] oe;} wexp_t;
  typedef struct packed {logic move; logic done; logic rdy; logic dir; logic err;} dexp_t;
  wexp_t wq[$];
  dexp_t dq[$];

  ddr3_lane_dm_tx_ctrl #(.WRITE_LATENCY(WL), .MOVE_GAP(MG)) dut (
    .FAB_CLK(FAB_CLK), .TX_SYNC_RST(TX_SYNC_RST),
    .WR_VALID(WR_VALID), .WR_READY(WR_READY), .WR_MASK(WR_MASK),
    .DLY_CMD_VALID(DLY_CMD_VALID), .DLY_CMD_LOAD(DLY_CMD_LOAD),
    .DLY_CMD_DIR(DLY_CMD_DIR), .DLY_CMD_STEPS(DLY_CMD_STEPS),
    .DLY_BUSY(DLY_BUSY), .DLY_DONE(DLY_DONE), .DLY_ERR(DLY_ERR),
    .TX_DATA_0(TX_DATA_0), .OE_DATA_0(OE_DATA_0),
    .DELAY_LINE_MOVE_0(DELAY_LINE_MOVE_0), .DELAY_LINE_DIRECTION_0(DELAY_LINE_DIRECTION_0),
    .DELAY_LINE_LOAD_0(DELAY_LINE_LOAD_0),
`ifdef DM_BURST_COUNT_EN
    .BURST_CNT(BURST_CNT),
`endif
    .DELAY_LINE_OUT_OF_RANGE_0(DELAY_LINE_OUT_OF_RANGE_0)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  task automatic to_drive();
    @(posedge FAB_CLK);
    #1;
  endtask

  task automatic to_sample();
    @(negedge FAB_CLK);
  endtask

  // Expected TX/OE for each of 16 cycles, derived from the burst request list.
  task automatic plan_writes(input logic [15:0] v, input logic [7:0] m [16]);
    wexp_t e;
    for (int k = 0; k < 16; k++) begin
      int j;
      j = k - WL;
      e.tx = (j >= 0 && v[j]) ? m[j] : 8'h00;
      e.oe = ((j >= 0 && v[j]) ? 4'b1111 : 4'b0000)
           | ((j + 1 >= 0 && v[j+1]) ? 4'b1000 : 4'b0000)
           | ((j - 1 >= 0 && v[j-1]) ? 4'b0001 : 4'b0000);
      wq.push_back(e);
    end
  endtask

  task automatic test_reset();
    TX_SYNC_RST = 1'b1;
    repeat (3) to_drive();
    TX_SYNC_RST = 1'b0;
    to_sample();
    checks += 2;
    if ({TX_DATA_0, OE_DATA_0, DLY_BUSY, DLY_DONE, DLY_ERR, DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0} !== 18'h0) begin
      errors++;
      $display("FAIL reset_outputs got tx=%h oe=%b busy=%b done=%b err=%b mv=%b ld=%b dir=%b want all 0",
               TX_DATA_0, OE_DATA_0, DLY_BUSY, DLY_DONE, DLY_ERR, DELAY_LINE_MOVE_0, DELAY_LINE_LOAD_0, DELAY_LINE_DIRECTION_0);
    end
    if (WR_READY !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b want 1", WR_READY);
    end
  endtask

  task automatic test_single_write();
    logic [7:0] m [16] = '{default: 8'h00};
    logic [15:0] v = 16'h0001;
    wexp_t e;
    m[0] = 8'hA5;
    plan_writes(v, m);
    for (int k = 0; k < 16; k++) begin
      to_drive();
      WR_VALID = v[k];
      WR_MASK = m[k];
      to_sample();
      e = wq.pop_front();
      checks += 2;
      if (TX_DATA_0 !== e.tx) begin errors++; $display("FAIL single_tx c=%0d got %h want %h", k, TX_DATA_0, e.tx); end
      if (OE_DATA_0 !== e.oe) begin errors++; $display("FAIL single_oe c=%0d got %b want %b", k, OE_DATA_0, e.oe); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] m [16] = '{default: 8'h00};
    logic [15:0] v = 16'h0007;
    wexp_t e;
    m[0] = 8'h01; m[1] = 8'h02; m[2] = 8'h03;
    plan_writes(v, m);
    for (int k = 0; k < 16; k++) begin
      to_drive();
      WR_VALID = v[k];
      WR_MASK = m[k];
      to_sample();
      e = wq.pop_front();
      checks += 3;
      if (WR_READY !== 1'b1) begin errors++; $display("FAIL b2b_ready c=%0d got %b want 1", k, WR_READY); end
      if (TX_DATA_0 !== e.tx) begin errors++; $display("FAIL b2b_tx c=%0d got %h want %h", k, TX_DATA_0, e.tx); end
      if (OE_DATA_0 !== e.oe) begin errors++; $display("FAIL b2b_oe c=%0d got %b want %b", k, OE_DATA_0, e.oe); end
    end
  endtask

  task automatic test_gap();
    logic [7:0] m [16] = '{default: 8'h00};
    logic [15:0] v = 16'h0005;
    wexp_t e;
    m[0] = 8'h11; m[2] = 8'h22;
    plan_writes(v, m);
    for (int k = 0; k < 16; k++) begin
      to_drive();
      WR_VALID = v[k];
      WR_MASK = m[k];
      to_sample();
      e = wq.pop_front();
      checks += 2;
      if (TX_DATA_0 !== e.tx) begin errors++; $display("FAIL gap_tx c=%0d got %h want %h", k, TX_DATA_0, e.tx); end
      if (OE_DATA_0 !== e.oe) begin errors++; $display("FAIL gap_oe c=%0d got %b want %b", k, OE_DATA_0, e.oe); end
    end
`ifdef DM_BURST_COUNT_EN
    checks++;
    if (BURST_CNT !== 16'd6) begin errors++; $display("FAIL burst_cnt got %0d want 6", BURST_CNT); end
`endif
  endtask

  task automatic test_delay_move();
    dexp_t d;
    to_drive();
    DLY_CMD_VALID = 1'b1; DLY_CMD_LOAD = 1'b0; DLY_CMD_DIR = 1'b1; DLY_CMD_STEPS = 8'd3;
    to_sample();
    checks++;
    if (WR_READY !== 1'b1) begin errors++; $display("FAIL move_ready_at_cmd got %b want 1", WR_READY); end
    for (int c = 1; c <= 3 * MG + 3; c++) begin
      d.move = ((c - 1) % MG == 0) && ((c - 1) / MG < 3);
      d.done = c == 1 + 3 * MG;
      d.rdy = c > 1 + 3 * MG;
      d.dir = 1'b1;
      d.err = 1'b0;
      dq.push_back(d);
    end
    for (int c = 1; c <= 3 * MG + 3; c++) begin
      to_drive();
      DLY_CMD_VALID = 1'b0;
      to_sample();
      d = dq.pop_front();
      checks += 5;
      if (DELAY_LINE_MOVE_0 !== d.move) begin errors++; $display("FAIL move_pulse c=%0d got %b want %b", c, DELAY_LINE_MOVE_0, d.move); end
      if (DLY_DONE !== d.done) begin errors++; $display("FAIL move_done c=%0d got %b want %b", c, DLY_DONE, d.done); end
      if (WR_READY !== d.rdy) begin errors++; $display("FAIL move_ready c=%0d got %b want %b", c, WR_READY, d.rdy); end
      if (DELAY_LINE_DIRECTION_0 !== d.dir) begin errors++; $display("FAIL move_dir c=%0d got %b want %b", c, DELAY_LINE_DIRECTION_0, d.dir); end
      if (DLY_ERR !== d.err) begin errors++; $display("FAIL move_err c=%0d got %b want %b", c, DLY_ERR, d.err); end
    end
  endtask

  task automatic test_out_of_range();
    dexp_t d;
    to_drive();
    DLY_CMD_VALID = 1'b1; DLY_CMD_LOAD = 1'b0; DLY_CMD_DIR = 1'b0; DLY_CMD_STEPS = 8'd5;
    to_sample();
    for (int c = 1; c <= 12; c++) begin
      d.move = c == 1 || c == 1 + MG;
      d.done = c == 3 + MG;
      d.rdy = c >= 4 + MG;
      d.dir = 1'b0;
      d.err = c >= 3 + MG;
      dq.push_back(d);
    end
    for (int c = 1; c <= 12; c++) begin
      to_drive();
      DLY_CMD_VALID = 1'b0;
      DELAY_LINE_OUT_OF_RANGE_0 = (c == 2 + MG) || (c == 3 + MG);
      to_sample();
      d = dq.pop_front();
      checks += 5;
      if (DELAY_LINE_MOVE_0 !== d.move) begin errors++; $display("FAIL oor_pulse c=%0d got %b want %b", c, DELAY_LINE_MOVE_0, d.move); end
      if (DLY_DONE !== d.done) begin errors++; $display("FAIL oor_done c=%0d got %b want %b", c, DLY_DONE, d.done); end
      if (WR_READY !== d.rdy) begin errors++; $display("FAIL oor_ready c=%0d got %b want %b", c, WR_READY, d.rdy); end
      if (DELAY_LINE_DIRECTION_0 !== d.dir) begin errors++; $display("FAIL oor_dir c=%0d got %b want %b", c, DELAY_LINE_DIRECTION_0, d.dir); end
      if (DLY_ERR !== d.err) begin errors++; $display("FAIL oor_err c=%0d got %b want %b", c, DLY_ERR, d.err); end
    end
    to_drive();
    DLY_CMD_VALID = 1'b1; DLY_CMD_LOAD = 1'b1;
    to_sample();
    to_drive();
    DLY_CMD_VALID = 1'b0; DLY_CMD_LOAD = 1'b0;
    to_sample();
    checks += 3;
    if (DELAY_LINE_LOAD_0 !== 1'b1) begin errors++; $display("FAIL load_pulse got %b want 1", DELAY_LINE_LOAD_0); end
    if (DLY_ERR !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", DLY_ERR); end
    if (DELAY_LINE_MOVE_0 !== 1'b0) begin errors++; $display("FAIL load_no_move got %b want 0", DELAY_LINE_MOVE_0); end
    to_drive();
    to_sample();
    checks += 2;
    if (DLY_DONE !== 1'b1) begin errors++; $display("FAIL load_done got %b want 1", DLY_DONE); end
    if (DELAY_LINE_LOAD_0 !== 1'b0) begin errors++; $display("FAIL load_single got %b want 0", DELAY_LINE_LOAD_0); end
    to_drive();
    to_sample();
    checks++;
    if (WR_READY !== 1'b1) begin errors++; $display("FAIL load_ready got %b want 1", WR_READY); end
  endtask

  task automatic test_reset_mid_flight();
    to_drive();
    WR_VALID = 1'b1; WR_MASK = 8'h5A;
    to_sample();
    to_drive();
    WR_VALID = 1'b0; DLY_CMD_VALID = 1'b1; DLY_CMD_DIR = 1'b1; DLY_CMD_STEPS = 8'd5;
    to_sample();
    to_drive();
    DLY_CMD_VALID = 1'b0;
    to_sample();
    checks++;
    if (DELAY_LINE_MOVE_0 !== 1'b1) begin errors++; $display("FAIL rst_pre_move got %b want 1", DELAY_LINE_MOVE_0); end
    to_drive();
    TX_SYNC_RST = 1'b1;
    to_sample();
    to_drive();
    to_sample();
    checks += 2;
    if ({TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0, DLY_BUSY, DELAY_LINE_DIRECTION_0} !== 15'h0) begin
      errors++;
      $display("FAIL rst_during got tx=%h oe=%b mv=%b busy=%b dir=%b want all 0", TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0, DLY_BUSY, DELAY_LINE_DIRECTION_0);
    end
    if (WR_READY !== 1'b0) begin errors++; $display("FAIL rst_during_ready got %b want 0", WR_READY); end
    to_drive();
    TX_SYNC_RST = 1'b0;
    to_sample();
    checks++;
    if (WR_READY !== 1'b1) begin errors++; $display("FAIL rst_after_ready got %b want 1", WR_READY); end
`ifdef DM_BURST_COUNT_EN
    checks++;
    if (BURST_CNT !== 16'd0) begin errors++; $display("FAIL rst_burst_cnt got %0d want 0", BURST_CNT); end
`endif
    for (int c = 0; c < 10; c++) begin
      checks++;
      if ({TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0, DLY_BUSY, DLY_DONE, DLY_ERR} !== 16'h0) begin
        errors++;
        $display("FAIL rst_after c=%0d got tx=%h oe=%b mv=%b busy=%b done=%b err=%b want all 0",
                 c, TX_DATA_0, OE_DATA_0, DELAY_LINE_MOVE_0, DLY_BUSY, DLY_DONE, DLY_ERR);
      end
      to_drive();
      to_sample();
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_gap();
    test_delay_move();
    test_out_of_range();
    test_reset_mid_flight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ddr3_lane_dm_tx_ctrl.md
Name: ddr3_lane_dm_tx_ctrl

Overview:
Fabric-side write-path controller for one DDR3 data-mask lane. It converts accepted BL8 write-mask requests into the 8-bit TX_DATA_0 and 4-bit OE_DATA_0 words, including write-latency alignment and preamble/postamble OE framing. It also sequences the lane's output delay line through MOVE/DIRECTION/LOAD pulses. It sits directly upstream of the DM lane IOD wrapper, on FAB_CLK, with FAB_CLK at 1/4 of the DDR clock (8:1 gearing, one BL8 burst per FAB_CLK cycle).

Parameters:
WRITE_LATENCY, 4, FAB_CLK cycles from request acceptance to the burst on TX_DATA_0; legal range 2..8
MOVE_GAP, 4, minimum FAB_CLK cycles between successive DELAY_LINE_MOVE pulses; legal range 2..15

Ports:
FAB_CLK  input  1  fabric clock; all logic on the rising edge
TX_SYNC_RST  input  1  synchronous reset, active-high
WR_VALID  input  1  write-burst request valid
WR_READY  output  1  request accepted when WR_VALID and WR_READY are both high
WR_MASK  input  8  per-beat mask; bit i = beat i (bit 0 first in time); 1 = byte masked
DLY_CMD_VALID  input  1  delay command strobe, sampled only in IDLE
DLY_CMD_LOAD  input  1  1 = reload the default delay (ignores DIR/STEPS)
DLY_CMD_DIR  input  1  step direction, forwarded to DELAY_LINE_DIRECTION_0
DLY_CMD_STEPS  input  8  number of MOVE pulses to issue
DLY_BUSY  output  1  delay FSM not in IDLE
DLY_DONE  output  1  one-cycle pulse on command completion
DLY_ERR  output  1  sticky; set on out-of-range; cleared by the next accepted command
TX_DATA_0  output  8  to IOD, DM serial bits
OE_DATA_0  output  4  to IOD, one OE bit per DDR clock; bit 0 first
DELAY_LINE_MOVE_0  output  1  to IOD
DELAY_LINE_DIRECTION_0  output  1  to IOD
DELAY_LINE_LOAD_0  output  1  to IOD
DELAY_LINE_OUT_OF_RANGE_0  input  1  from IOD

Behaviour:
- Reset: synchronous, active-high. All outputs are 0 during reset and on the first cycle after it, except WR_READY, which rises on the first cycle after reset. Reset clears the write pipeline (in-flight bursts are dropped), forces the FSM to IDLE, and clears DLY_ERR. A reset mid-command stops MOVE pulses immediately.
- WR_READY = !DLY_BUSY. A command accepted in IDLE drops WR_READY from the next cycle. Writes and delay moves never overlap.
- Write pipeline: a shift pipeline of depth WRITE_LATENCY carries {valid, mask}. A burst accepted at cycle T drives TX_DATA_0 = WR_MASK at cycle T+WRITE_LATENCY. All outputs are registered. Back-to-back acceptance every cycle is supported. On non-burst cycles, TX_DATA_0 = 8'h00.
- OE framing, per output cycle C, OR-merged:
  - burst in C → 4'b1111
  - burst in C+1 → 4'b1000 (preamble)
  - burst in C-1 → 4'b0001 (postamble)
  - Consequences: back-to-back bursts give continuous 4'b1111; a one-cycle gap gives 4'b1001.
- Delay FSM states: IDLE, LOAD, MOVE, GAP, DONE.
  - IDLE: on DLY_CMD_VALID, latch DIR/STEPS, clear DLY_ERR, and go to LOAD if DLY_CMD_LOAD, else to DONE if STEPS==0, else to MOVE.
  - LOAD: DELAY_LINE_LOAD_0 high for exactly 1 cycle → DONE.
  - MOVE: DELAY_LINE_MOVE_0 high for 1 cycle, decrement the remaining count → GAP.
  - GAP: wait MOVE_GAP-1 cycles. If DELAY_LINE_OUT_OF_RANGE_0 is sampled high at any point in GAP, set DLY_ERR → DONE with no further pulses. Otherwise, at the end of GAP go to MOVE if remaining != 0, else DONE.
  - DONE: DLY_DONE high for 1 cycle → IDLE.
- DELAY_LINE_DIRECTION_0 holds the latched DIR from the entry into MOVE through DONE, and holds its last value in IDLE.
- DLY_CMD_VALID outside IDLE is ignored.

Optional Feature:
DM_BURST_COUNT_EN. When defined, add output BURST_CNT[15:0]: a saturating count (stops at 16'hFFFF) of bursts driven onto TX_DATA_0, cleared by reset. When undefined, the port and the counter are absent and behaviour is otherwise identical.

Test Plan:
- Reset, then one write with WR_MASK=8'hA5 at cycle T (WRITE_LATENCY=4) → TX_DATA_0=8'hA5 and OE_DATA_0=4'b1111 at T+4; OE_DATA_0=4'b1000 at T+3; 4'b0001 at T+5; otherwise 0.
- Three back-to-back writes (8'h01, 8'h02, 8'h03) → TX_DATA_0 = 01,02,03 on consecutive cycles; OE_DATA_0 = 1000,1111,1111,1111,0001.
- Writes at T and T+2 → OE_DATA_0 on the gap cycle = 4'b1001, TX_DATA_0 = 8'h00.
- Delay cmd DIR=1, STEPS=3, MOVE_GAP=4 → exactly 3 single-cycle MOVE pulses spaced 4 cycles apart, DIRECTION=1 throughout, then DLY_DONE pulse. WR_READY is low from the cycle after the command until DONE returns to IDLE.
- Delay cmd STEPS=5 with OUT_OF_RANGE asserted after the 2nd pulse → 2 pulses only, DLY_ERR=1, DLY_DONE pulse. The next command clears DLY_ERR.
- Reset asserted while a burst is in flight and during GAP → no burst emerges after reset, no further MOVE, all outputs 0, WR_READY=1 on the first cycle after reset. With DM_BURST_COUNT_EN, BURST_CNT=0.
